// File: rtl/core_instr_line_buffer_if.sv
// naive_bus: simple request/grant bus with separate read and write channels.
// The grant is combinational in the request cycle; read data follows one cycle later.
interface naive_bus;
    logic        rd_req;
    logic        rd_gnt;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );
endinterface

// File: rtl/core_instr_line_buffer.sv
// Single-entry, 4-word instruction line buffer between the core fetch port and memory.
// Hits are granted combinationally; a miss refills the whole line before any grant.
module core_instr_line_buffer (
    input logic      clk,
    input logic      rst_n,
    input logic      i_flush,
    naive_bus.slave  core_slave,
    naive_bus.master mem_master
);
    localparam int unsigned WORDS = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned TAG_W = 28;
    localparam int unsigned CNT_W = 3;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state_q, state_d;
    logic              valid_q;
    logic              poisoned_q;
    logic              pending_q;
    logic [CNT_W-1:0]  req_cnt_q;
    logic [CNT_W-1:0]  rsp_cnt_q;
    logic [TAG_W-1:0]  tag_q;
    logic [TAG_W-1:0]  base_tag_q;
    logic [DW-1:0]     line_q [WORDS];
    logic [DW-1:0]     rd_data_q;

    logic hit_c;
    logic miss_c;
    logic mem_req_c;
    logic last_capture_c;
    logic core_gnt_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and lookup/refill control
    always_comb begin
        state_d        = state_q;
        hit_c          = 1'b0;
        miss_c         = 1'b0;
        mem_req_c      = 1'b0;
        last_capture_c = 1'b0;
        case (state_q)
            IDLE: begin
                hit_c = valid_q && (tag_q == core_slave.rd_addr[31:4]);
                if (core_slave.rd_req && !hit_c) begin
                    miss_c  = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_req_c      = (req_cnt_q < CNT_W'(WORDS));
                last_capture_c = pending_q && (rsp_cnt_q == CNT_W'(WORDS - 1));
                if (last_capture_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_gnt_c = core_slave.rd_req && hit_c;

    // Line storage, refill counters and validity tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            poisoned_q <= 1'b0;
            pending_q  <= 1'b0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            tag_q      <= '0;
            base_tag_q <= '0;
            rd_data_q  <= '0;
            for (int i = 0; i < int'(WORDS); i++) line_q[i] <= '0;
        end else begin
            pending_q <= mem_req_c && mem_master.rd_gnt;
            if (mem_req_c && mem_master.rd_gnt) req_cnt_q <= req_cnt_q + CNT_W'(1);
            if (pending_q) begin
                line_q[rsp_cnt_q[1:0]] <= mem_master.rd_data;
                rsp_cnt_q              <= rsp_cnt_q + CNT_W'(1);
            end
            if (core_gnt_c) rd_data_q <= line_q[core_slave.rd_addr[3:2]];

            if (miss_c) begin
                base_tag_q <= core_slave.rd_addr[31:4];
                valid_q    <= 1'b0;
                poisoned_q <= 1'b0;
                req_cnt_q  <= '0;
                rsp_cnt_q  <= '0;
            end else if (state_q == IDLE && i_flush) begin
                valid_q <= 1'b0;
            end

            // A flush seen at any point of the refill, including its last edge, leaves the line invalid
            if (state_q == FILL && i_flush) poisoned_q <= 1'b1;
            if (last_capture_c) begin
                tag_q      <= base_tag_q;
                valid_q    <= !(poisoned_q || i_flush);
                poisoned_q <= 1'b0;
            end
        end
    end

    assign core_slave.rd_gnt  = core_gnt_c;
    assign core_slave.rd_data = rd_data_q;
    assign core_slave.wr_gnt  = core_slave.wr_req;

    // Refill words are consecutive within the line, so the offset never carries into the tag
    assign mem_master.rd_req  = mem_req_c;
    assign mem_master.rd_be   = mem_req_c ? 4'hF : 4'h0;
    assign mem_master.rd_addr = {base_tag_q, req_cnt_q[1:0], 2'b00};
    assign mem_master.wr_req  = 1'b0;
    assign mem_master.wr_be   = 4'h0;
    assign mem_master.wr_addr = '0;
    assign mem_master.wr_data = '0;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{core_slave.rd_be, core_slave.wr_be, core_slave.wr_addr,
                               core_slave.wr_data, mem_master.wr_gnt};
endmodule

// File: tb/tb_core_instr_line_buffer.sv
// Directed bench for core_instr_line_buffer: a table of hit/idle vectors plus hand-built
// sequences for refill timing, wait states, redirects, flushes, address wrap and reset.
module tb_core_instr_line_buffer;
    logic clk = 1'b0;
    logic rst_n;
    logic i_flush;

    naive_bus core_bus ();
    naive_bus mem_bus ();

    core_instr_line_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (i_flush),
        .core_slave (core_bus),
        .mem_master (mem_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: data = address ^ key, optional wait cycles before each grant
    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } log_t;

    log_t        log_q[$];
    int          cyc = 0;
    int          wcnt = 0;
    int          mem_wait = 0;
    logic [31:0] key = 32'h0;

    assign mem_bus.rd_gnt = mem_bus.rd_req && (wcnt >= mem_wait);
    assign mem_bus.wr_gnt = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_bus.rd_req && !mem_bus.rd_gnt) wcnt <= wcnt + 1;
        else                                   wcnt <= 0;
        if (mem_bus.rd_req && mem_bus.rd_gnt) begin
            log_q.push_back('{mem_bus.rd_addr, cyc});
            mem_bus.rd_data <= mem_bus.rd_addr ^ key;
        end
    end

    // Continuous protocol monitor on the memory side
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("mem_rd_be", 32'(mem_bus.rd_be), mem_bus.rd_req ? 32'hF : 32'h0);
            check("mem_wr_tie", 32'({mem_bus.wr_req, mem_bus.wr_be}) | mem_bus.wr_addr | mem_bus.wr_data, 32'h0);
            if (prev_wait) begin
                check("wait_rd_req_held", 32'(mem_bus.rd_req), 32'h1);
                check("wait_rd_addr_held", mem_bus.rd_addr, prev_addr);
            end
            prev_wait = mem_bus.rd_req && !mem_bus.rd_gnt;
            prev_addr = mem_bus.rd_addr;
        end else begin
            prev_wait = 1'b0;
        end
    end

    int t0;

    // Starts at posedge+1; holds the request until granted, optionally pulsing i_flush k cycles in
    task automatic run_fetch(input logic [31:0] addr, input int flush_at, input int exp_lat,
                             input logic [31:0] exp_data, input string name);
        int k;
        k = 0;
        t0 = cyc;
        core_bus.rd_addr = addr;
        core_bus.rd_req  = 1'b1;
        i_flush          = (flush_at == 0);
        #1;
        while (!core_bus.rd_gnt && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            i_flush = (k == flush_at);
            #1;
        end
        i_flush = 1'b0;
        check({name, "_latency"}, 32'(k), 32'(exp_lat));
        @(posedge clk);
        #1;
        check({name, "_rd_data"}, core_bus.rd_data, exp_data);
        core_bus.rd_req = 1'b0;
    endtask

    task automatic check_log(input int idx0, input logic [31:0] base, input int first_cyc,
                             input int stride, input string name);
        for (int i = 0; i < 4; i++) begin
            if (idx0 + i < log_q.size()) begin
                check({name, "_mem_addr"}, log_q[idx0 + i].addr, base + 32'(4 * i));
                if (first_cyc >= 0)
                    check({name, "_mem_cycle"}, 32'(log_q[idx0 + i].cyc), 32'(first_cyc + stride * i));
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        req;
        logic        wr;
        logic [3:0]  be;
        logic        exp_gnt;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h0000_0104, 1'b1, 1'b0, 4'hF, 1'b1, 32'h0000_0104};
        vecs[1] = '{32'h0000_0108, 1'b1, 1'b1, 4'h0, 1'b1, 32'h0000_0108};
        vecs[2] = '{32'h0000_010C, 1'b1, 1'b0, 4'h3, 1'b1, 32'h0000_010C};
        vecs[3] = '{32'h0000_0100, 1'b1, 1'b0, 4'h0, 1'b1, 32'h0000_0100};
        vecs[4] = '{32'h0000_0200, 1'b0, 1'b1, 4'hF, 1'b0, 32'h0000_0100};
        vecs[5] = '{32'h0000_010C, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0000_0100};
        vecs[6] = '{32'h0000_0108, 1'b1, 1'b0, 4'hF, 1'b1, 32'h0000_0108};

        rst_n            = 1'b0;
        i_flush          = 1'b0;
        core_bus.rd_req  = 1'b1;
        core_bus.rd_addr = 32'h0;
        core_bus.rd_be   = 4'hF;
        core_bus.wr_req  = 1'b1;
        core_bus.wr_be   = 4'hF;
        core_bus.wr_addr = 32'h0;
        core_bus.wr_data = 32'hDEAD_BEEF;
        mem_bus.rd_data  = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_core_gnt", 32'(core_bus.rd_gnt), 32'h0);
        check("reset_mem_req", 32'(mem_bus.rd_req), 32'h0);
        check("reset_rd_data", core_bus.rd_data, 32'h0);
        check("reset_wr_gnt", 32'(core_bus.wr_gnt), 32'h1);
        core_bus.rd_req = 1'b0;
        core_bus.wr_req = 1'b0;
        rst_n = 1'b1;

        // Cold fetch with zero-wait memory
        log_q.delete();
        run_fetch(32'h0000_0100, -1, 6, 32'h0000_0100, "cold");
        check("cold_mem_count", 32'(log_q.size()), 32'd4);
        check_log(0, 32'h0000_0100, t0 + 1, 1, "cold");

        // Hits, idle cycles and absorbed writes from the vector table
        log_q.delete();
        for (int i = 0; i < 7; i++) begin
            core_bus.rd_addr = vecs[i].addr;
            core_bus.rd_req  = vecs[i].req;
            core_bus.rd_be   = vecs[i].be;
            core_bus.wr_req  = vecs[i].wr;
            #1;
            check($sformatf("vec%0d_gnt", i), 32'(core_bus.rd_gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_wr_gnt", i), 32'(core_bus.wr_gnt), 32'(vecs[i].wr));
            check($sformatf("vec%0d_mem_req", i), 32'(mem_bus.rd_req), 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd_data", i), core_bus.rd_data, vecs[i].exp_data);
        end
        core_bus.rd_req = 1'b0;
        core_bus.wr_req = 1'b0;
        check("hits_no_mem_reads", 32'(log_q.size()), 32'd0);

        // Two wait cycles per word
        key = 32'hA5A5_0000;
        mem_wait = 2;
        log_q.delete();
        run_fetch(32'h0000_0304, -1, 14, 32'h0000_0304 ^ 32'hA5A5_0000, "wait");
        check("wait_mem_count", 32'(log_q.size()), 32'd4);
        check_log(0, 32'h0000_0300, t0 + 3, 3, "wait");
        mem_wait = 0;
        run_fetch(32'h0000_030C, -1, 0, 32'h0000_030C ^ 32'hA5A5_0000, "wait_hit");

        // Redirect to 0x200 while 0x100 is filling
        key = 32'h3C3C_0000;
        log_q.delete();
        t0 = cyc;
        core_bus.rd_addr = 32'h0000_0100;
        core_bus.rd_req  = 1'b1;
        #1;
        check("jump_miss_gnt", 32'(core_bus.rd_gnt), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            core_bus.rd_addr = 32'h0000_0200;
            #1;
            check($sformatf("jump_fill_gnt%0d", i), 32'(core_bus.rd_gnt), 32'h0);
        end
        @(posedge clk);
        #1;
        core_bus.rd_addr = 32'h0000_010C;
        #1;
        check("jump_old_line_hit", 32'(core_bus.rd_gnt), 32'h1);
        @(posedge clk);
        #1;
        check("jump_old_line_data", core_bus.rd_data, 32'h0000_010C ^ 32'h3C3C_0000);
        run_fetch(32'h0000_0200, -1, 6, 32'h0000_0200 ^ 32'h3C3C_0000, "jump_new");
        check("jump_mem_count", 32'(log_q.size()), 32'd8);
        check_log(0, 32'h0000_0100, -1, 0, "jump_old");
        check_log(4, 32'h0000_0200, -1, 0, "jump_new");

        // Flush mid-fill and on the last capture edge poisons the fill
        key = 32'h5A5A_0000;
        log_q.delete();
        run_fetch(32'h0000_0400, 2, 12, 32'h0000_0400 ^ 32'h5A5A_0000, "flush_mid");
        check("flush_mid_mem_count", 32'(log_q.size()), 32'd8);
        check_log(0, 32'h0000_0400, -1, 0, "flush_mid_a");
        check_log(4, 32'h0000_0400, -1, 0, "flush_mid_b");
        run_fetch(32'h0000_0488, 5, 12, 32'h0000_0488 ^ 32'h5A5A_0000, "flush_last");

        // Flush in IDLE invalidates the resident line
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        run_fetch(32'h0000_0484, -1, 6, 32'h0000_0484 ^ 32'h5A5A_0000, "flush_idle");

        // Flush in the miss cycle does not poison the new fill
        run_fetch(32'h0000_0500, 0, 6, 32'h0000_0500 ^ 32'h5A5A_0000, "flush_miss");
        run_fetch(32'h0000_0504, -1, 0, 32'h0000_0504 ^ 32'h5A5A_0000, "flush_miss_hit");

        // Top-of-address-space line
        log_q.delete();
        run_fetch(32'hFFFF_FFF8, -1, 6, 32'hFFFF_FFF8 ^ 32'h5A5A_0000, "wrap");
        check("wrap_mem_count", 32'(log_q.size()), 32'd4);
        check_log(0, 32'hFFFF_FFF0, -1, 0, "wrap");

        // Reset mid-fill
        key = 32'h0F0F_0000;
        log_q.delete();
        core_bus.rd_addr = 32'h0000_0600;
        core_bus.rd_req  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_fill_mem_req", 32'(mem_bus.rd_req), 32'h0);
        check("rst_fill_core_gnt", 32'(core_bus.rd_gnt), 32'h0);
        check("rst_fill_rd_data", core_bus.rd_data, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_fill_mem_count", 32'(log_q.size()), 32'd1);
        rst_n = 1'b1;
        log_q.delete();
        run_fetch(32'h0000_0600, -1, 6, 32'h0000_0600 ^ 32'h0F0F_0000, "after_rst");
        check("after_rst_mem_count", 32'(log_q.size()), 32'd4);
        check_log(0, 32'h0000_0600, t0 + 1, 1, "after_rst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
